// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: word width, sigma rotate/shift amounts, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sha2_pkg;

   localparam int WORD_SIZE = 32;
   localparam int ROUNDS    = 64;

   // Small sigma amounts for SHA-256 (two rotates and one plain shift each).
   localparam int S0_R1 = 7;
   localparam int S0_R2 = 18;
   localparam int S0_SH = 3;
   localparam int S1_R1 = 17;
   localparam int S1_R2 = 19;
   localparam int S1_SH = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of bits needed to count 0..value-1.
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   localparam int IDX_W = clogb2(ROUNDS);

endpackage

// File: rtl/message_schedule_gen_if.sv
// Block-in / schedule-word-out handshake bundle of the message schedule generator.
// Latency: none (wiring only).
// Backpressure: block_valid/block_ready on the input side, w_valid/w_ready on the output side.
// master = schedule generator, slave = block source plus round logic.
interface message_schedule_gen_if;
   import sha2_pkg::*;

   logic                    block_valid;
   logic                    block_ready;
   logic [WORD_SIZE*16-1:0] block_data;
   logic                    w_valid;
   logic                    w_ready;
   logic [WORD_SIZE-1:0]    message_schedule_value;
   logic [IDX_W-1:0]        message_schedule_index;
   logic                    block_done;

   modport master (
      input  block_valid, block_data, w_ready,
      output block_ready, w_valid, message_schedule_value, message_schedule_index, block_done
   );

   modport slave (
      output block_valid, block_data, w_ready,
      input  block_ready, w_valid, message_schedule_value, message_schedule_index, block_done
   );

endinterface

// File: rtl/ms_sigma.sv
// Next SHA-256 schedule word from the 16-word window: sig1(w14)+w9+sig0(w1)+w0 mod 2^32.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the result.
// Ports: i_w14/i_w9/i_w1/i_w0 window taps, o_next the new word.
module ms_sigma
   import sha2_pkg::*;
(
   input  logic [WORD_SIZE-1:0] i_w14,
   input  logic [WORD_SIZE-1:0] i_w9,
   input  logic [WORD_SIZE-1:0] i_w1,
   input  logic [WORD_SIZE-1:0] i_w0,
   output logic [WORD_SIZE-1:0] o_next
);

   function automatic logic [WORD_SIZE-1:0] rotr(input logic [WORD_SIZE-1:0] x, input int n);
      return (x >> n) | (x << (WORD_SIZE - n));
   endfunction

   logic [WORD_SIZE-1:0] w_sig0;
   logic [WORD_SIZE-1:0] w_sig1;

   assign w_sig0 = rotr(i_w1,  S0_R1) ^ rotr(i_w1,  S0_R2) ^ (i_w1  >> S0_SH);
   assign w_sig1 = rotr(i_w14, S1_R1) ^ rotr(i_w14, S1_R2) ^ (i_w14 >> S1_SH);
   assign o_next = w_sig1 + i_w9 + w_sig0 + i_w0;

endmodule

// File: rtl/message_schedule_gen.sv
// Expands one padded 512-bit block into W[0..63] and streams one word per accepted handshake.
// Latency: W[0] valid one cycle after block acceptance; one word per cycle while w_ready is high.
// Backpressure: w_ready low freezes window, index and outputs; block_ready only in IDLE.
// Ports: clock, reset (async active-low), clear (sync abort), ms (handshake bundle, master side).
module message_schedule_gen
   import sha2_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   message_schedule_gen_if.master ms
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WORD_SIZE-1:0] r_win [16];
   logic [IDX_W-1:0]     r_t;
   logic                 r_done;

   logic                 w_consume;
   logic                 w_last;
   logic                 w_accept;
   logic [WORD_SIZE-1:0] w_new;

   assign w_consume = (r_state == RUN) && ms.w_ready;
   assign w_last    = w_consume && (r_t == IDX_W'(ROUNDS - 1));
   assign w_accept  = (r_state == IDLE) && ms.block_valid;

   ms_sigma u_sigma (
      .i_w14  (r_win[14]),
      .i_w9   (r_win[9]),
      .i_w1   (r_win[1]),
      .i_w0   (r_win[0]),
      .o_next (w_new)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (ms.block_valid) w_state_nxt = RUN;
            RUN:     if (w_last)         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Window, index and done pulse. Words computed while W[0..15] drain are
   // already the real W[16..], since the taps only ever look backwards.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
         r_t    <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (clear) begin
            r_t <= '0;
         end else if (w_accept) begin
            for (int i = 0; i < 16; i++)
               r_win[i] <= ms.block_data[WORD_SIZE*(15-i) +: WORD_SIZE];
            r_t <= '0;
         end else if (w_consume) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_new;
            r_t       <= w_last ? '0 : r_t + 1'b1;
            r_done    <= w_last;
         end
      end
   end

   // All outputs decode registers only; w_ready has no combinational path out.
   assign ms.block_ready            = (r_state == IDLE);
   assign ms.w_valid                = (r_state == RUN);
   assign ms.message_schedule_value = r_win[0];
   assign ms.message_schedule_index = r_t;
   assign ms.block_done             = r_done;

endmodule

// File: tb/tb_message_schedule_gen.sv
// Self-checking bench for message_schedule_gen against a plain-array SHA-256 schedule model.
// Latency: checks W[0] one cycle after acceptance and the done pulse after W[63].
// Backpressure: exercises random w_ready stalls, clear and asynchronous reset mid-block.
module tb_message_schedule_gen;
   import sha2_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic clear = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0]  exp_w [64];
   logic [511:0] abc_blk;

   message_schedule_gen_if bus ();

   message_schedule_gen dut (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .ms    (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Textbook recurrence over the full 64-entry array.
   task automatic gen_model(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
   endtask

   function automatic logic [31:0] abc_const(input int n);
      case (n)
         0:       return 32'h61626380;
         15:      return 32'h00000018;
         16:      return 32'h61626380;
         17:      return 32'h000F0000;
         default: return 32'h12B1EDEB;
      endcase
   endfunction

   function automatic logic [511:0] rnd_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   task automatic load(input logic [511:0] blk);
      int cyc = 0;
      while (bus.block_ready !== 1'b1 && cyc < 200) begin
         step();
         cyc++;
      end
      chk("load_ready", bus.block_ready, 1);
      bus.block_data  = blk;
      bus.block_valid = 1'b1;
      step();
      bus.block_valid = 1'b0;
      gen_model(blk);
   endtask

   // Consume the whole schedule from W[0]; ends on the block_done cycle.
   task automatic drain(input bit stall, input bit is_abc, input string tag);
      int n   = 0;
      int cyc = 0;
      while (n < 64 && cyc < 2000) begin
         bus.w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         chk({tag, "_valid"}, bus.w_valid, 1);
         chk({tag, "_ready"}, bus.block_ready, 0);
         chk({tag, "_done"},  bus.block_done, 0);
         chk({tag, "_index"}, bus.message_schedule_index, n);
         chk({tag, "_value"}, bus.message_schedule_value, exp_w[n]);
         if (is_abc && (n == 0 || n == 15 || n == 16 || n == 17 || n == 63))
            chk({tag, "_abc_const"}, bus.message_schedule_value, abc_const(n));
         step();
         if (bus.w_ready) n++;
         cyc++;
      end
      bus.w_ready = 1'b0;
      chk({tag, "_words_consumed"}, n, 64);
      chk({tag, "_done_pulse"}, bus.block_done, 1);
      chk({tag, "_end_ready"}, bus.block_ready, 1);
      chk({tag, "_end_valid"}, bus.w_valid, 0);
   endtask

   initial begin
      logic [511:0] blk_b;
      abc_blk          = '0;
      abc_blk[511:480] = 32'h61626380;
      abc_blk[31:0]    = 32'h00000018;
      bus.block_valid  = 1'b0;
      bus.block_data   = '0;
      bus.w_ready      = 1'b0;

      // Reset values
      #2;
      chk("rst_valid", bus.w_valid, 0);
      chk("rst_ready", bus.block_ready, 1);
      chk("rst_done",  bus.block_done, 0);
      chk("rst_value", bus.message_schedule_value, 0);
      chk("rst_index", bus.message_schedule_index, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      step();
      chk("idle_valid", bus.w_valid, 0);

      // "abc" at full rate, then with random stalls
      load(abc_blk);
      drain(1'b0, 1'b1, "abc_full");
      step();
      chk("done_one_cycle", bus.block_done, 0);
      load(abc_blk);
      drain(1'b1, 1'b1, "abc_stall");
      step();

      // Random block with stalls
      load(rnd_block());
      drain(1'b1, 1'b0, "rnd_stall");
      step();

      // Back-to-back: block_valid held high, new data presented during RUN
      blk_b           = rnd_block();
      bus.block_data  = abc_blk;
      bus.block_valid = 1'b1;
      step();
      gen_model(abc_blk);
      bus.block_data  = blk_b;
      drain(1'b0, 1'b1, "b2b_first");
      step();
      bus.block_valid = 1'b0;
      gen_model(blk_b);
      drain(1'b1, 1'b0, "b2b_second");
      step();

      // clear at t=30, then clear together with block_valid in IDLE
      load(abc_blk);
      bus.w_ready = 1'b1;
      for (int k = 0; k < 30; k++) step();
      chk("clr_pre_index", bus.message_schedule_index, 30);
      clear           = 1'b1;
      bus.block_valid = 1'b1;
      bus.block_data  = abc_blk;
      step();
      chk("clr_valid", bus.w_valid, 0);
      chk("clr_ready", bus.block_ready, 1);
      chk("clr_index", bus.message_schedule_index, 0);
      chk("clr_done",  bus.block_done, 0);
      step();
      clear           = 1'b0;
      bus.block_valid = 1'b0;
      bus.w_ready     = 1'b0;
      chk("clr_idle_not_accepted", bus.w_valid, 0);
      load(abc_blk);
      drain(1'b0, 1'b1, "after_clear");
      step();

      // clear on the last word suppresses block_done
      load(rnd_block());
      bus.w_ready = 1'b1;
      for (int k = 0; k < 63; k++) step();
      chk("clr_last_index", bus.message_schedule_index, 63);
      clear = 1'b1;
      step();
      clear       = 1'b0;
      bus.w_ready = 1'b0;
      chk("clr_last_done",  bus.block_done, 0);
      chk("clr_last_valid", bus.w_valid, 0);
      chk("clr_last_ready", bus.block_ready, 1);

      // Asynchronous reset at t=40, between clock edges
      load(rnd_block());
      bus.w_ready = 1'b1;
      for (int k = 0; k < 40; k++) step();
      chk("arst_pre_index", bus.message_schedule_index, 40);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", bus.w_valid, 0);
      chk("arst_ready", bus.block_ready, 1);
      chk("arst_index", bus.message_schedule_index, 0);
      chk("arst_value", bus.message_schedule_value, 0);
      chk("arst_done",  bus.block_done, 0);
      bus.w_ready = 1'b0;
      @(negedge clock) reset = 1'b1;
      step();
      load(abc_blk);
      drain(1'b1, 1'b1, "after_arst");
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
